m2_job_loader: RTL and testbench



---
 rtl/m2_job_loader.sv | 165 ++++++++++++++++
 tb/tb_m2_job_loader.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m2_job_loader.sv
// rtl/m2_job_loader.sv - loads a 16-word job into header RAM and paces go_m2 pulses per nonce
module m2_job_loader #(
  parameter int unsigned HASH_CYCLES = 24,
  parameter int unsigned NONCE_IDX   = 3
) (
  input  logic        clk_h,
  input  logic        rst_n,
  input  logic        abort,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] hash_count,
  output logic        hdr_wr_en,
  output logic [3:0]  hdr_wr_addr,
  output logic [31:0] hdr_wr_data,
  output logic        go_m2,
  output logic        start_stop,
  output logic        busy,
  output logic        done,
  output logic [31:0] nonce_cur
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_GO,
    S_WAIT,
    S_BUMP,
    S_FIN
  } state_t;

  // The final pass waits one extra cycle because FIN replaces both BUMP and GO.
  localparam logic [7:0] WAIT_BUMP = 8'(HASH_CYCLES - 3);
  localparam logic [7:0] WAIT_FIN  = 8'(HASH_CYCLES - 2);
  localparam logic [3:0] NIDX      = 4'(NONCE_IDX);

  state_t      state, state_nx;
  logic [3:0]  widx, widx_nx;
  logic [31:0] remain, remain_nx;
  logic [7:0]  wcnt, wcnt_nx;
  logic [31:0] nonce_q, nonce_nx;
  logic        rdy_q;
  logic        run_q, run_nx;
  logic        wr_en_nx;
  logic [3:0]  wr_addr_nx;
  logic [31:0] wr_data_nx;
  logic        go_nx;
  logic        done_nx;
  logic        accept;

  assign in_ready   = rdy_q & ~abort;
  assign accept     = in_valid & in_ready;
  assign busy       = (state != S_IDLE);
  assign start_stop = run_q;
  assign nonce_cur  = nonce_q;

  always_comb begin
    state_nx   = state;
    widx_nx    = widx;
    remain_nx  = remain;
    wcnt_nx    = wcnt;
    nonce_nx   = nonce_q;
    run_nx     = run_q;
    wr_en_nx   = 1'b0;
    wr_addr_nx = hdr_wr_addr;
    wr_data_nx = hdr_wr_data;
    go_nx      = 1'b0;
    done_nx    = 1'b0;

    case (state)
      S_IDLE: begin
        run_nx = 1'b0;
        if (accept) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = 4'd0;
          wr_data_nx = in_data;
          remain_nx  = hash_count;
          widx_nx    = 4'd1;
          if (NIDX == 4'd0) nonce_nx = in_data;
          state_nx   = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = widx;
          wr_data_nx = in_data;
          widx_nx    = widx + 4'd1;
          if (widx == NIDX) nonce_nx = in_data;
          if (widx == 4'd15) state_nx = (remain == 32'd0) ? S_FIN : S_GO;
        end
      end
      S_GO: begin
        go_nx     = 1'b1;
        run_nx    = 1'b1;
        remain_nx = remain - 32'd1;
        wcnt_nx   = 8'd0;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (remain == 32'd0) begin
          if (wcnt == WAIT_FIN) state_nx = S_FIN;
          else                  wcnt_nx  = wcnt + 8'd1;
        end else begin
          if (wcnt == WAIT_BUMP) state_nx = S_BUMP;
          else                   wcnt_nx  = wcnt + 8'd1;
        end
      end
      S_BUMP: begin
        wr_en_nx   = 1'b1;
        wr_addr_nx = NIDX;
        wr_data_nx = nonce_q + 32'd1;
        nonce_nx   = nonce_q + 32'd1;
        state_nx   = S_GO;
      end
      S_FIN: begin
        done_nx  = 1'b1;
        run_nx   = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // Cancel kills anything decided this cycle; already-registered outputs still land.
    if (abort) begin
      state_nx = S_IDLE;
      nonce_nx = nonce_q;
      wr_en_nx = 1'b0;
      go_nx    = 1'b0;
      done_nx  = 1'b0;
      run_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      widx        <= 4'd0;
      remain      <= 32'd0;
      wcnt        <= 8'd0;
      nonce_q     <= 32'd0;
      rdy_q       <= 1'b0;
      run_q       <= 1'b0;
      hdr_wr_en   <= 1'b0;
      hdr_wr_addr <= 4'd0;
      hdr_wr_data <= 32'd0;
      go_m2       <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nx;
      widx        <= widx_nx;
      remain      <= remain_nx;
      wcnt        <= wcnt_nx;
      nonce_q     <= nonce_nx;
      rdy_q       <= (state_nx == S_IDLE) || (state_nx == S_LOAD);
      run_q       <= run_nx;
      hdr_wr_en   <= wr_en_nx;
      hdr_wr_addr <= wr_addr_nx;
      hdr_wr_data <= wr_data_nx;
      go_m2       <= go_nx;
      done        <= done_nx;
    end
  end

endmodule

// File: tb/tb_m2_job_loader.sv
// tb/tb_m2_job_loader.sv - scoreboard bench for m2_job_loader
module tb_m2_job_loader;
  localparam int H  = 24;
  localparam int NI = 3;

  logic        clk_h = 1'b0;
  logic        rst_n = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] hash_count = '0;
  logic        hdr_wr_en;
  logic [3:0]  hdr_wr_addr;
  logic [31:0] hdr_wr_data;
  logic        go_m2, start_stop, busy, done;
  logic [31:0] nonce_cur;

  m2_job_loader #(.HASH_CYCLES(H), .NONCE_IDX(NI)) dut (
    .clk_h(clk_h), .rst_n(rst_n), .abort(abort), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .hash_count(hash_count),
    .hdr_wr_en(hdr_wr_en), .hdr_wr_addr(hdr_wr_addr), .hdr_wr_data(hdr_wr_data),
    .go_m2(go_m2), .start_stop(start_stop), .busy(busy), .done(done),
    .nonce_cur(nonce_cur)
  );

  always #5 clk_h = ~clk_h;

  // kind: 0 = header write, 1 = go_m2, 2 = done; ss = expected start_stop or -1
  typedef struct {
    int          cyc;
    int          kind;
    logic [3:0]  addr;
    logic [31:0] data;
    int          ss;
  } ev_t;

  ev_t sb[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  always @(posedge clk_h) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input int k, input logic [3:0] a, input logic [31:0] d, input int s);
    ev_t e;
    e.cyc = c; e.kind = k; e.addr = a; e.data = d; e.ss = s;
    sb.push_back(e);
  endtask

  task automatic mon_ev(input int k);
    ev_t e;
    logic [31:0] d;
    logic ok;
    total++;
    d = (k == 0) ? hdr_wr_data : nonce_cur;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: kind=%0d cyc=%0d addr=%h data=%h", k, cyc, hdr_wr_addr, d);
      return;
    end
    e = sb.pop_front();
    ok = (e.kind == k) && (e.cyc == cyc) && (d === e.data);
    if (k == 0 && hdr_wr_addr !== e.addr) ok = 1'b0;
    if (e.ss >= 0 && start_stop !== e.ss[0]) ok = 1'b0;
    if (!ok) begin
      bad++;
      $display("FAIL event: got kind=%0d cyc=%0d addr=%h data=%h ss=%0b, expected kind=%0d cyc=%0d addr=%h data=%h ss=%0d",
               k, cyc, hdr_wr_addr, d, start_stop, e.kind, e.cyc, e.addr, e.data, e.ss);
    end
  endtask

  always @(negedge clk_h) begin
    if (rst_n) begin
      if (hdr_wr_en) mon_ev(0);
      if (go_m2)     mon_ev(1);
      if (done)      mon_ev(2);
    end
  end

  task automatic step();
    @(posedge clk_h);
    #1;
  endtask

  // Reference model: each handshake yields a write one cycle later; after word 15
  // (cycle t) the nonce passes start at t+2, H apart, each bump lands one cycle
  // before the next pass, and done follows the last pass by H.
  task automatic send_job(input logic [31:0] w[16], input logic [31:0] hc, input int mode,
                          input int nw, output int t_last);
    logic hs;
    logic [31:0] n;
    t_last = -1;
    for (int i = 0; i < nw; i++) begin
      int guard = 0;
      forever begin
        in_data    = w[i];
        hash_count = (i == 0) ? hc : $urandom;
        in_valid   = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
        hs = in_valid && in_ready;
        if (hs) begin
          push(cyc + 1, 0, 4'(i), w[i], -1);
          if (i == 15) t_last = cyc;
        end
        step();
        if (hs) break;
        guard++;
        if (guard > 200) begin
          total++; bad++;
          $display("FAIL handshake_timeout: word %0d never accepted", i);
          in_valid = 1'b0;
          return;
        end
      end
    end
    in_valid = 1'b0;
    if (nw < 16) return;
    n = w[NI];
    if (hc == 0) begin
      push(t_last + 2, 2, 4'd0, n, 0);
    end else begin
      for (int unsigned i = 0; i < hc; i++) begin
        int g = t_last + 2 + int'(i) * H;
        push(g, 1, 4'd0, n + i, 1);
        if (i + 1 < hc) push(g + H - 1, 0, 4'(NI), n + i + 1, -1);
      end
      push(t_last + 2 + int'(hc) * H, 2, 4'd0, n + hc - 1, -1);
    end
  endtask

  task automatic drain(output logic ss_any);
    int g = 0;
    ss_any = 1'b0;
    while (sb.size() != 0 && g < 3000) begin
      step();
      if (start_stop) ss_any = 1'b1;
      g++;
    end
    chk("drain_queue_empty", sb.size(), 0);
    repeat (3) step();
  endtask

  task automatic rand_words(output logic [31:0] w[16]);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
  endtask

  initial begin
    logic [31:0] w[16];
    int t;
    int a;
    logic ssa;

    repeat (3) step();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_en", hdr_wr_en, 0);
    chk("reset_nonce", nonce_cur, 0);
    chk("reset_start_stop", start_stop, 0);
    rst_n = 1'b1;
    step();
    chk("post_reset_in_ready", in_ready, 1);
    chk("post_reset_busy", busy, 0);

    // basic job
    for (int i = 0; i < 16; i++) w[i] = 32'h100 + i;
    send_job(w, 32'd3, 0, 16, t);
    drain(ssa);
    chk("basic_nonce_end", nonce_cur, 32'h105);

    // stalled load
    rand_words(w);
    send_job(w, 32'd2, 1, 16, t);
    drain(ssa);

    // zero hashes
    rand_words(w);
    send_job(w, 32'd0, 0, 16, t);
    drain(ssa);
    chk("zero_hash_start_stop_never", ssa, 0);

    // nonce wrap
    rand_words(w);
    w[NI] = 32'hFFFF_FFFF;
    send_job(w, 32'd2, 2, 16, t);
    drain(ssa);
    chk("wrap_nonce_end", nonce_cur, 32'h0);

    // abort in WAIT after the second pass starts
    rand_words(w);
    send_job(w, 32'd5, 0, 16, t);
    a = t + 2 + H + 5;
    while (cyc < a) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].cyc > a) sb.delete(k);
    chk("abort_busy", busy, 0);
    chk("abort_start_stop", start_stop, 0);
    repeat (3 * H) step();
    chk("abort_no_more_events", sb.size(), 0);

    // abort beats a handshake in IDLE
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    abort    = 1'b1;
    #1;
    chk("abort_in_ready_forced", in_ready, 0);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_no_accept_busy", busy, 0);
    step();

    rand_words(w);
    send_job(w, $urandom_range(1, 3), 2, 16, t);
    drain(ssa);

    // async reset mid-load
    rand_words(w);
    send_job(w, 32'd2, 0, 7, t);
    drain(ssa);
    chk("midload_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_in_ready", in_ready, 0);
    chk("async_wr_en", hdr_wr_en, 0);
    chk("async_wr_addr", hdr_wr_addr, 0);
    sb.delete();
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("release_in_ready", in_ready, 1);
    rand_words(w);
    send_job(w, $urandom_range(1, 3), 2, 16, t);
    drain(ssa);

    for (int j = 0; j < 3; j++) begin
      rand_words(w);
      send_job(w, $urandom_range(0, 4), $urandom_range(0, 2), 16, t);
      drain(ssa);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
